// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot and auto-reload modes.
// Optional count-rate prescaler is enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_next;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, count_next;
  logic        irq_flag, flag_next, en_clr;
  logic        en, im, wr_ctrl, wr_preset, tick;
  logic [1:0]  mode;

  assign en        = ctrl[0];
  assign mode      = ctrl[2:1];
  assign im        = ctrl[3];
  assign wr_ctrl   = We && (Addr == 2'd0);
  assign wr_preset = We && (Addr == 2'd1);

  if (PRESCALE < 1) begin : g_prescale_check
    $error("PRESCALE must be at least 1");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSC_W-1:0] psc;

  assign tick = (psc == PSC_W'(PRESCALE - 1));

  // Prescaler only runs while counting; wraps on each tick.
  always_ff @(posedge clk) begin
    if (reset || state != CNT || tick) psc <= '0;
    else                               psc <= psc + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    flag_next  = irq_flag;
    en_clr     = 1'b0;
    case (state)
      IDLE: if (en) state_next = LOAD;
      LOAD: begin
        count_next = preset;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (tick) begin
          if (count > 32'd1) begin
            count_next = count - 32'd1;
          end else begin
            count_next = '0;
            flag_next  = 1'b1;
            state_next = INT;
          end
        end
      end
      INT: begin
        if (mode == 2'd1) begin
          flag_next  = 1'b0;
          state_next = LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A register write acknowledges the interrupt, even one raised on the same edge.
    if (wr_ctrl || wr_preset) flag_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      irq_flag <= flag_next;
      if (wr_ctrl)     ctrl    <= DIn[3:0];
      else if (en_clr) ctrl[0] <= 1'b0;
      if (wr_preset)   preset  <= DIn;
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      2'd0:    DOut = {28'd0, ctrl};
      2'd1:    DOut = preset;
      2'd2:    DOut = count;
      default: DOut = '0;
    endcase
  end

  assign IRQ = irq_flag & im;

endmodule
